// File: rtl/crtc_pkg.sv
// Shared definitions for the character-rate CRT controller: counter widths,
// register indices, the vertical state encoding and the register-file payload.
package crtc_pkg;

    localparam int unsigned HC_W    = 8;
    localparam int unsigned VC_W    = 7;
    localparam int unsigned RA_W    = 5;
    localparam int unsigned MA_W    = 14;
    localparam int unsigned ADDR_W  = 5;
    localparam int unsigned DATA_W  = 8;
    localparam int unsigned STHI_W  = 6;
    localparam int unsigned SW_W    = 4;

    // Register indices of the programmable timing and start-address registers.
    localparam logic [ADDR_W-1:0] R_HTOT  = 5'd0;
    localparam logic [ADDR_W-1:0] R_HDISP = 5'd1;
    localparam logic [ADDR_W-1:0] R_HSYNC = 5'd2;
    localparam logic [ADDR_W-1:0] R_SYNCW = 5'd3;
    localparam logic [ADDR_W-1:0] R_VTOT  = 5'd4;
    localparam logic [ADDR_W-1:0] R_VADJ  = 5'd5;
    localparam logic [ADDR_W-1:0] R_VDISP = 5'd6;
    localparam logic [ADDR_W-1:0] R_VSYNC = 5'd7;
    localparam logic [ADDR_W-1:0] R_MAXRA = 5'd9;
    localparam logic [ADDR_W-1:0] R_STHI  = 5'd12;
    localparam logic [ADDR_W-1:0] R_STLO  = 5'd13;

    typedef enum logic {
        V_ACTIVE = 1'b0,
        V_ADJUST = 1'b1
    } vstate_e;

    // Programmed timing registers as seen by the counter logic.
    typedef struct packed {
        logic [DATA_W-1:0] htot;
        logic [DATA_W-1:0] hdisp;
        logic [DATA_W-1:0] hsync_pos;
        logic [DATA_W-1:0] sync_w;
        logic [DATA_W-1:0] vtot;
        logic [DATA_W-1:0] vadj;
        logic [DATA_W-1:0] vdisp;
        logic [DATA_W-1:0] vsync_pos;
        logic [DATA_W-1:0] max_ra;
        logic [STHI_W-1:0] start_hi;
        logic [DATA_W-1:0] start_lo;
    } crtc_regs_t;

endpackage

// File: rtl/crtc_regfile.sv
// CPU-facing register file: address latch, write decode, reset defaults and
// the registered R12/R13 read-back mux.
//   clock, reset   : clock and asynchronous active-low reset
//   cs, rs, we, di : CPU select, register select (0 addr / 1 data), strobe, data
//   regs           : current register contents for the timing logic
//   dout           : read data, R12/R13 when addressed, else 0
module crtc_regfile
    import crtc_pkg::*;
#(
    parameter crtc_regs_t RST_REGS = '0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cs,
    input  logic              rs,
    input  logic              we,
    input  logic [DATA_W-1:0] di,
    output crtc_regs_t        regs,
    output logic [DATA_W-1:0] dout
);

    logic [ADDR_W-1:0] addr_q, addr_d;
    crtc_regs_t        regs_q, regs_d;
    logic [DATA_W-1:0] dout_q, dout_d;

    // Write decode and read mux.
    always_comb begin
        addr_d = addr_q;
        regs_d = regs_q;
        dout_d = '0;

        if (cs && we) begin
            if (!rs) begin
                addr_d = di[ADDR_W-1:0];
            end else begin
                case (addr_q)
                    R_HTOT:  regs_d.htot      = di;
                    R_HDISP: regs_d.hdisp     = di;
                    R_HSYNC: regs_d.hsync_pos = di;
                    R_SYNCW: regs_d.sync_w    = di;
                    R_VTOT:  regs_d.vtot      = di;
                    R_VADJ:  regs_d.vadj      = di;
                    R_VDISP: regs_d.vdisp     = di;
                    R_VSYNC: regs_d.vsync_pos = di;
                    R_MAXRA: regs_d.max_ra    = di;
                    R_STHI:  regs_d.start_hi  = di[STHI_W-1:0];
                    R_STLO:  regs_d.start_lo  = di;
                    default: ;
                endcase
            end
        end

        case (addr_q)
            R_STHI:  dout_d = {2'b00, regs_q.start_hi};
            R_STLO:  dout_d = regs_q.start_lo;
            default: dout_d = '0;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            addr_q <= '0;
            regs_q <= RST_REGS;
            dout_q <= '0;
        end else begin
            addr_q <= addr_d;
            regs_q <= regs_d;
            dout_q <= dout_d;
        end
    end

    assign regs = regs_q;
    assign dout = dout_q;

endmodule

// File: rtl/crtc.sv
// Character-rate CRT controller (6845 subset). Advances one character per cce
// and produces display enable, syncs and the video memory / raster address.
//   clock, reset       : clock and asynchronous active-low reset
//   cce                : character clock enable
//   cs, rs, we, di     : CPU register interface
//   dout               : CPU read data (the 6845 "do" pin; do is a keyword)
//   de, hsync, vsync   : display enable and active-high syncs
//   ma, ra             : memory address and raster line within the row
module crtc
    import crtc_pkg::*;
#(
    parameter logic [DATA_W-1:0] H_TOTAL = 8'd63,
    parameter logic [DATA_W-1:0] H_DISP  = 8'd32,
    parameter logic [DATA_W-1:0] H_SYNC  = 8'd41,
    parameter logic [DATA_W-1:0] SYNC_W  = 8'h2A,
    parameter logic [DATA_W-1:0] V_TOTAL = 8'd38,
    parameter logic [DATA_W-1:0] V_ADJ   = 8'd0,
    parameter logic [DATA_W-1:0] V_DISP  = 8'd31,
    parameter logic [DATA_W-1:0] V_SYNC  = 8'd34,
    parameter logic [DATA_W-1:0] MAX_RA  = 8'd7
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cce,
    input  logic              cs,
    input  logic              rs,
    input  logic              we,
    input  logic [DATA_W-1:0] di,
    output logic [DATA_W-1:0] dout,
    output logic              de,
    output logic              hsync,
    output logic              vsync,
    output logic [MA_W-1:0]   ma,
    output logic [RA_W-1:0]   ra
);

    localparam crtc_regs_t RST_REGS = '{
        htot: H_TOTAL, hdisp: H_DISP, hsync_pos: H_SYNC, sync_w: SYNC_W,
        vtot: V_TOTAL, vadj: V_ADJ, vdisp: V_DISP, vsync_pos: V_SYNC,
        max_ra: MAX_RA, start_hi: '0, start_lo: '0
    };

    crtc_regs_t regs;

    crtc_regfile #(
        .RST_REGS (RST_REGS)
    ) u_regfile (
        .clock (clock),
        .reset (reset),
        .cs    (cs),
        .rs    (rs),
        .we    (we),
        .di    (di),
        .regs  (regs),
        .dout  (dout)
    );

    // Timing state describes the character currently being generated.
    logic [HC_W-1:0] hc_q, hc_d;
    logic [RA_W-1:0] ra_cnt_q, ra_cnt_d;
    logic [VC_W-1:0] vc_q, vc_d;
    vstate_e         vstate_q, vstate_d;
    logic [MA_W-1:0] ma_row_q, ma_row_d;
    logic            hs_run_q, hs_run_d;   // pulse carried over from earlier characters
    logic [SW_W-1:0] hs_cnt_q, hs_cnt_d;   // characters left after the current one
    logic            vs_on_q, vs_on_d;     // current scanline is inside vsync
    logic [SW_W-1:0] vs_cnt_q, vs_cnt_d;   // scanlines left after the current one

    logic            de_q, de_d;
    logic            hsync_q, hsync_d;
    logic            vsync_q, vsync_d;
    logic [MA_W-1:0] ma_q, ma_d;
    logic [RA_W-1:0] ra_q, ra_d;

    logic            line_end;
    logic            frame_end;
    logic            hs_start;
    logic [SW_W-1:0] hs_left;

    // Character/line/frame sequencing and output decode.
    always_comb begin
        hc_d      = hc_q;
        ra_cnt_d  = ra_cnt_q;
        vc_d      = vc_q;
        vstate_d  = vstate_q;
        ma_row_d  = ma_row_q;
        hs_run_d  = hs_run_q;
        hs_cnt_d  = hs_cnt_q;
        vs_on_d   = vs_on_q;
        vs_cnt_d  = vs_cnt_q;
        de_d      = de_q;
        hsync_d   = hsync_q;
        vsync_d   = vsync_q;
        ma_d      = ma_q;
        ra_d      = ra_q;
        frame_end = 1'b0;
        line_end  = (hc_q == regs.htot);
        hs_start  = !hs_run_q && (hc_q == regs.hsync_pos);
        hs_left   = regs.sync_w[SW_W-1:0] - SW_W'(1);

        if (cce) begin
            // Outputs present the character the counters are on now.
            de_d    = (hc_q < regs.hdisp) && ({1'b0, vc_q} < regs.vdisp)
                      && (vstate_q == V_ACTIVE);
            hsync_d = hs_run_q || hs_start;
            vsync_d = vs_on_q;
            ma_d    = ma_row_q + MA_W'(hc_q);
            ra_d    = ra_cnt_q;

            // Width 0 in the register wraps hs_left to 15, giving 16 characters.
            if (hs_run_q) begin
                hs_run_d = (hs_cnt_q != '0);
                hs_cnt_d = hs_cnt_q - SW_W'(1);
            end else if (hs_start) begin
                hs_run_d = (hs_left != '0);
                hs_cnt_d = hs_left - SW_W'(1);
            end else begin
                hs_run_d = 1'b0;
            end

            hc_d = line_end ? '0 : hc_q + HC_W'(1);

            if (line_end) begin
                case (vstate_q)
                    V_ACTIVE: begin
                        if ({3'b000, ra_cnt_q} == regs.max_ra) begin
                            ra_cnt_d = '0;
                            ma_row_d = ma_row_q + MA_W'(regs.hdisp);
                            vc_d     = vc_q + VC_W'(1);
                            if ({1'b0, vc_q} == regs.vtot) begin
                                if (regs.vadj == '0) begin
                                    frame_end = 1'b1;
                                end else begin
                                    vstate_d = V_ADJUST;
                                end
                            end
                        end else begin
                            ra_cnt_d = ra_cnt_q + RA_W'(1);
                        end
                    end
                    V_ADJUST: begin
                        if (DATA_W'(ra_cnt_q) + DATA_W'(1) == regs.vadj) begin
                            frame_end = 1'b1;
                        end else begin
                            ra_cnt_d = ra_cnt_q + RA_W'(1);
                        end
                    end
                    default: vstate_d = V_ACTIVE;
                endcase

                if (frame_end) begin
                    vc_d     = '0;
                    ra_cnt_d = '0;
                    vstate_d = V_ACTIVE;
                    ma_row_d = {regs.start_hi, regs.start_lo};
                end

                // vsync is decided once per scanline, for the line about to start.
                if (vs_on_q && (vs_cnt_q != '0)) begin
                    vs_cnt_d = vs_cnt_q - SW_W'(1);
                end else if (({1'b0, vc_d} == regs.vsync_pos) && (ra_cnt_d == '0)
                             && (vstate_d == V_ACTIVE)) begin
                    vs_on_d  = 1'b1;
                    vs_cnt_d = regs.sync_w[DATA_W-1:SW_W] - SW_W'(1);
                end else begin
                    vs_on_d  = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hc_q     <= '0;
            ra_cnt_q <= '0;
            vc_q     <= '0;
            vstate_q <= V_ACTIVE;
            ma_row_q <= '0;
            hs_run_q <= 1'b0;
            hs_cnt_q <= '0;
            vs_on_q  <= 1'b0;
            vs_cnt_q <= '0;
            de_q     <= 1'b0;
            hsync_q  <= 1'b0;
            vsync_q  <= 1'b0;
            ma_q     <= '0;
            ra_q     <= '0;
        end else begin
            hc_q     <= hc_d;
            ra_cnt_q <= ra_cnt_d;
            vc_q     <= vc_d;
            vstate_q <= vstate_d;
            ma_row_q <= ma_row_d;
            hs_run_q <= hs_run_d;
            hs_cnt_q <= hs_cnt_d;
            vs_on_q  <= vs_on_d;
            vs_cnt_q <= vs_cnt_d;
            de_q     <= de_d;
            hsync_q  <= hsync_d;
            vsync_q  <= vsync_d;
            ma_q     <= ma_d;
            ra_q     <= ra_d;
        end
    end

    assign de    = de_q;
    assign hsync = hsync_q;
    assign vsync = vsync_q;
    assign ma    = ma_q;
    assign ra    = ra_q;

endmodule
